// File: rtl/demux8_deser_if.sv
// Bit-serial input / byte output bundle for demux8_deser.
// master = producer/consumer side, slave = the deserialiser.
interface demux8_deser_if;
  logic       in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] slot;
  logic       parity_err;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, slot, parity_err
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, data_out, out_valid, slot, parity_err
  );
endinterface

// File: rtl/demux8_deser.sv
// Serial-to-parallel collector: steers one bit per beat into a byte, then holds it
// under a valid/ready handshake. Optional trailing even-parity beat: DEMUX8_PARITY_EN.
module demux8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  demux8_deser_if.slave  bus
);

`ifdef DEMUX8_PARITY_EN
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = 4'd8;

  function automatic logic even_par(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction
`else
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST = 3'd7;
`endif

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [7:0]     data_r, data_s;
  logic           perr_r, perr_s;
  logic [2:0]     pos_s;
  logic [2:0]     slot_s;
  logic           data_beat_s;

  // The beat counter always ascends; the slot is its (possibly mirrored) image,
  // parked at the starting slot during the parity beat.
  always_comb begin
    pos_s       = cnt_r[2:0];
    data_beat_s = 1'b1;
`ifdef DEMUX8_PARITY_EN
    if (cnt_r[3]) begin
      pos_s       = 3'd0;
      data_beat_s = 1'b0;
    end else begin
      pos_s       = cnt_r[2:0];
      data_beat_s = 1'b1;
    end
`endif
    if (MSB_FIRST) begin
      slot_s = 3'd7 - pos_s;
    end else begin
      slot_s = pos_s;
    end
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    perr_s  = perr_r;
    if (flush) begin
      state_s = FILL;
      cnt_s   = '0;
      data_s  = 8'h00;
      perr_s  = 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (bus.in_valid) begin
            if (data_beat_s) begin
              data_s[slot_s] = bus.in;
            end else begin
              data_s = data_r;
            end
            if (cnt_r == LAST) begin
              cnt_s   = '0;
              state_s = HOLD;
`ifdef DEMUX8_PARITY_EN
              perr_s  = even_par(data_r, bus.in);
`else
              perr_s  = 1'b0;
`endif
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end else begin
            state_s = FILL;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_s = FILL;
            perr_s  = 1'b0;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = FILL;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      cnt_r   <= '0;
      data_r  <= 8'h00;
      perr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      perr_r  <= perr_s;
    end
  end

  assign bus.in_ready   = (state_r == FILL);
  assign bus.out_valid  = (state_r == HOLD);
  assign bus.data_out   = data_r;
  assign bus.slot       = slot_s;
  assign bus.parity_err = perr_r;

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: LSB-first and MSB-first instances share one
// bit stream and are checked every cycle against a frame-level model.
module tb_demux8_deser;

`ifdef DEMUX8_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;

  demux8_deser_if bus0 ();
  demux8_deser_if bus1 ();

  demux8_deser #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .flush(flush), .bus(bus0));
  demux8_deser #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  always #5 clk = ~clk;

  // Model: count of beats taken in this frame, the two assembled bytes, hold flag.
  int         m_cnt;
  logic [7:0] m_byte [2];
  logic       m_hold;
  logic       m_perr;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      m_cnt = 0; m_hold = 1'b0; m_perr = 1'b0;
      m_byte[0] = 8'h00; m_byte[1] = 8'h00;
    end else if (!m_hold) begin
      if (bus0.in_valid) begin
        if (m_cnt < 8) begin
          m_byte[0][m_cnt]     = bus0.in;
          m_byte[1][7 - m_cnt] = bus0.in;
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == FRAME) begin
          m_cnt  = 0;
          m_hold = 1'b1;
          m_perr = (FRAME == 9) ? ((^m_byte[0]) ^ bus0.in) : 1'b0;
        end
      end
    end else if (bus0.out_ready) begin
      m_hold = 1'b0;
      m_perr = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("lsb.data_out",   bus0.data_out,           m_byte[0]);
      chk("msb.data_out",   bus1.data_out,           m_byte[1]);
      chk("lsb.out_valid",  {7'd0, bus0.out_valid},  {7'd0, m_hold});
      chk("msb.out_valid",  {7'd0, bus1.out_valid},  {7'd0, m_hold});
      chk("lsb.in_ready",   {7'd0, bus0.in_ready},   {7'd0, !m_hold});
      chk("msb.in_ready",   {7'd0, bus1.in_ready},   {7'd0, !m_hold});
      chk("lsb.slot",       {5'd0, bus0.slot},       (m_cnt < 8) ? 8'(m_cnt) : 8'd0);
      chk("msb.slot",       {5'd0, bus1.slot},       (m_cnt < 8) ? 8'(7 - m_cnt) : 8'd7);
      chk("lsb.parity_err", {7'd0, bus0.parity_err}, {7'd0, m_perr});
      chk("msb.parity_err", {7'd0, bus1.parity_err}, {7'd0, m_perr});
    end
  end

  // Present inputs for exactly one rising edge, then return to idle.
  task automatic drive(input logic v, input logic b, input logic rdy);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.in = v ? b : 1'bx;  bus1.in = v ? b : 1'bx;
    bus0.out_ready = rdy;  bus1.out_ready = rdy;
    @(negedge clk);
    bus0.in_valid = 1'b0;  bus1.in_valid = 1'b0;
    bus0.in = 1'bx;  bus1.in = 1'bx;
    bus0.out_ready = 1'b0;  bus1.out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p);
    for (int i = 0; i < 8; i++) drive(1'b1, b[i], 1'b0);
`ifdef DEMUX8_PARITY_EN
    drive(1'b1, p, 1'b0);
`endif
  endtask

  task automatic release_frame();
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_pair(input string name, input logic [7:0] e0, input logic [7:0] e1);
    chk({name, ".lsb_lit"}, bus0.data_out, e0);
    chk({name, ".msb_lit"}, bus1.data_out, e1);
    chk({name, ".valid_lit"}, {7'd0, bus0.out_valid & bus1.out_valid}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus0.in = 1'bx; bus1.in = 1'bx;
    bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.data_out",  bus0.data_out, 8'h00);
    chk("rst.out_valid", {7'd0, bus0.out_valid}, 8'd0);
    chk("rst.in_ready",  {7'd0, bus0.in_ready}, 8'd1);
    chk("rst.msb_slot",  {5'd0, bus1.slot}, 8'd7);
    rst = 1'b0;

    // Reset mid-frame after 3 accepted bits.
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.data_out",  bus0.data_out, 8'h00);
    chk("midrst.out_valid", {7'd0, bus0.out_valid}, 8'd0);
    chk("midrst.lsb_slot",  {5'd0, bus0.slot}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h01, 1'b1);
    chk_pair("after_rst", 8'h01, 8'h80);
    release_frame();

    // A5, held for 5 idle cycles, correct parity.
    send_frame(8'hA5, 1'b0);
    chk("a5.slot", {5'd0, bus0.slot}, 8'd0);
    repeat (5) drive(1'b0, 1'b0, 1'b0);
    chk_pair("a5", 8'hA5, 8'hA5);
    chk("a5.parity_err", {7'd0, bus0.parity_err}, 8'd0);
    release_frame();

    // A5 with a wrong parity bit.
    send_frame(8'hA5, 1'b1);
`ifdef DEMUX8_PARITY_EN
    chk("a5bad.parity_err", {7'd0, bus0.parity_err}, 8'd1);
`else
    chk("a5bad.parity_err", {7'd0, bus0.parity_err}, 8'd0);
`endif
    release_frame();

    // Backpressure: input offered during HOLD and on the release beat is ignored.
    send_frame(8'h96, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    chk_pair("hold96", 8'h96, 8'h69);
    drive(1'b1, 1'b1, 1'b1);
    chk("release.lsb_slot", {5'd0, bus0.slot}, 8'd0);
    send_frame(8'h3C, 1'b0);
    chk_pair("3c", 8'h3C, 8'h3C);
    release_frame();

    // Flush after 5 bits of FF.
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    flush = 1'b0;
    chk("flush.data_out",  bus0.data_out, 8'h00);
    chk("flush.lsb_slot",  {5'd0, bus0.slot}, 8'd0);
    chk("flush.out_valid", {7'd0, bus0.out_valid}, 8'd0);
    send_frame(8'h81, 1'b0);
    chk_pair("81", 8'h81, 8'h81);
    release_frame();
    repeat (2) drive(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
